// File: rtl/penta_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : penta_pkg
//  Description : Shared constants and the digit type for the base-5 adder.
//  Revision    : 1.0 - initial release
// ============================================================================
package penta_pkg;

    // Radix of the number system and the largest legal digit value
    localparam int PENTA_BASE      = 5;
    localparam int PENTA_MAX_DIGIT = 4;

    // Each base-5 digit is carried in a 3-bit slice (values 5..7 are illegal)
    localparam int DIGIT_W         = 3;

    typedef logic [DIGIT_W-1:0] penta_digit_t;

endpackage : penta_pkg
`default_nettype wire

// File: rtl/penta_digit_add.sv
`default_nettype none
// ============================================================================
//  Module      : penta_digit_add
//  Description : Single base-5 digit full adder (purely combinational).
//                Digits 5..7 are not rejected here; they follow the same
//                subtract-base-and-carry rule with the result truncated.
//  Revision    : 1.0 - initial release
// ============================================================================
module penta_digit_add
    import penta_pkg::*;
(
    input  penta_digit_t a,
    input  penta_digit_t b,
    input  logic         cin,
    output penta_digit_t s,
    output logic         cout
);

    // One extra bit holds the largest raw sum (7 + 7 + 1 = 15)
    localparam int RAW_W = DIGIT_W + 1;

    logic [RAW_W-1:0] raw;

    // Binary add, then fold back into base 5 when the sum reaches the radix
    always_comb begin
        raw  = RAW_W'(a) + RAW_W'(b) + RAW_W'(cin);
        s    = raw[DIGIT_W-1:0];
        cout = 1'b0;
        if (raw > RAW_W'(PENTA_MAX_DIGIT)) begin
            s    = DIGIT_W'(raw - RAW_W'(PENTA_BASE));
            cout = 1'b1;
        end
    end

endmodule : penta_digit_add
`default_nettype wire

// File: rtl/hw17.sv
`default_nettype none
// ============================================================================
//  Module      : hw17
//  Description : N_DIGITS-wide base-5 ripple adder with a one-cycle registered
//                result. Optional macro PENTA_ERR_EN adds a registered err
//                output that flags any captured digit above 4 and forces the
//                sum and carry to zero for that operand pair.
//  Revision    : 1.0 - initial release
// ============================================================================
module hw17
    import penta_pkg::*;
#(
    parameter int N_DIGITS = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    input  logic [DIGIT_W*N_DIGITS-1:0] A,
    input  logic [DIGIT_W*N_DIGITS-1:0] B,
    output logic                        out_valid,
    output logic                        cout,
    output logic [DIGIT_W*N_DIGITS-1:0] Sum
`ifdef PENTA_ERR_EN
    ,
    output logic                        err
`endif
);

    localparam int SUM_W = DIGIT_W * N_DIGITS;

    // Ripple chain: carry[0] is tied low, carry[N_DIGITS] is the final carry
    logic [N_DIGITS:0] carry;
    logic [SUM_W-1:0]  sum_raw;

    logic [SUM_W-1:0]  sum_q,   sum_d;
    logic              cout_q,  cout_d;
    logic              valid_q, valid_d;

    assign carry[0] = 1'b0;

    generate
        for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digit
            penta_digit_add u_digit (
                .a    (A[gi*DIGIT_W +: DIGIT_W]),
                .b    (B[gi*DIGIT_W +: DIGIT_W]),
                .cin  (carry[gi]),
                .s    (sum_raw[gi*DIGIT_W +: DIGIT_W]),
                .cout (carry[gi+1])
            );
        end
    endgenerate

`ifdef PENTA_ERR_EN
    logic range_err;
    logic err_q, err_d;

    // Flag any operand digit outside the legal base-5 range
    always_comb begin
        range_err = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if ((A[i*DIGIT_W +: DIGIT_W] > DIGIT_W'(PENTA_MAX_DIGIT)) ||
                (B[i*DIGIT_W +: DIGIT_W] > DIGIT_W'(PENTA_MAX_DIGIT))) begin
                range_err = 1'b1;
            end
        end
    end
`endif

    // Next-state: capture a new result when qualified, otherwise hold it
    always_comb begin
        sum_d   = sum_q;
        cout_d  = cout_q;
        valid_d = 1'b0;
`ifdef PENTA_ERR_EN
        err_d   = err_q;
`endif
        if (in_valid) begin
            valid_d = 1'b1;
            sum_d   = sum_raw;
            cout_d  = carry[N_DIGITS];
`ifdef PENTA_ERR_EN
            err_d   = range_err;
            if (range_err) begin
                sum_d  = '0;
                cout_d = 1'b0;
            end
`endif
        end
    end

    // Output registers; reset wins over a same-edge capture
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q   <= '0;
            cout_q  <= 1'b0;
            valid_q <= 1'b0;
`ifdef PENTA_ERR_EN
            err_q   <= 1'b0;
`endif
        end else begin
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            valid_q <= valid_d;
`ifdef PENTA_ERR_EN
            err_q   <= err_d;
`endif
        end
    end

    assign Sum       = sum_q;
    assign cout      = cout_q;
    assign out_valid = valid_q;
`ifdef PENTA_ERR_EN
    assign err       = err_q;
`endif

endmodule : hw17
`default_nettype wire

// File: tb/tb_hw17.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hw17
//  Description : Self-checking bench for hw17; one single-digit and one
//                two-digit instance driven in lockstep. Honors PENTA_ERR_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hw17;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [2:0] a1 = '0, b1 = '0;
    logic [5:0] a2 = '0, b2 = '0;

    logic       v1, co1, v2, co2;
    logic [2:0] s1;
    logic [5:0] s2;
`ifdef PENTA_ERR_EN
    logic       er1, er2;
`endif

    // Expected values held by the bench
    logic       e1_v, e1_co, e1_er, e2_v, e2_co, e2_er;
    logic [2:0] e1_s;
    logic [5:0] e2_s;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hw17 #(.N_DIGITS(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .A(a1), .B(b1),
        .out_valid(v1), .cout(co1), .Sum(s1)
`ifdef PENTA_ERR_EN
        , .err(er1)
`endif
    );

    hw17 #(.N_DIGITS(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .A(a2), .B(b2),
        .out_valid(v2), .cout(co2), .Sum(s2)
`ifdef PENTA_ERR_EN
        , .err(er2)
`endif
    );

    // Reference: legal operands are added as integers and re-expressed in base 5;
    // operands with an illegal digit fall back to the per-digit textual rule.
    function automatic void model(input int n, input logic [23:0] a, input logic [23:0] b,
                                  output logic [23:0] s, output logic co, output logic er);
        int  va, vb, tot, p, c, raw, da, db;
        bit  legal;
        legal = 1'b1;
        s = '0; co = 1'b0; er = 1'b0;
        for (int i = 0; i < n; i++)
            if (a[3*i +: 3] > 3'd4 || b[3*i +: 3] > 3'd4) legal = 1'b0;
`ifdef PENTA_ERR_EN
        if (!legal) begin
            er = 1'b1;
            return;
        end
`endif
        if (legal) begin
            va = 0; vb = 0; p = 1;
            for (int i = 0; i < n; i++) begin
                va += int'(a[3*i +: 3]) * p;
                vb += int'(b[3*i +: 3]) * p;
                p  *= 5;
            end
            tot = va + vb;
            co  = (tot >= p);
            tot = tot % p;
            for (int i = 0; i < n; i++) begin
                s[3*i +: 3] = 3'(tot % 5);
                tot = tot / 5;
            end
        end else begin
            c = 0;
            for (int i = 0; i < n; i++) begin
                da = int'(a[3*i +: 3]);
                db = int'(b[3*i +: 3]);
                raw = da + db + c;
                if (raw >= 5) begin
                    s[3*i +: 3] = 3'((raw - 5) % 8);
                    c = 1;
                end else begin
                    s[3*i +: 3] = 3'(raw);
                    c = 0;
                end
            end
            co = (c == 1);
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("v1",   32'(v1),  32'(e1_v));
        chk("sum1", 32'(s1),  32'(e1_s));
        chk("co1",  32'(co1), 32'(e1_co));
        chk("v2",   32'(v2),  32'(e2_v));
        chk("sum2", 32'(s2),  32'(e2_s));
        chk("co2",  32'(co2), 32'(e2_co));
`ifdef PENTA_ERR_EN
        chk("err1", 32'(er1), 32'(e1_er));
        chk("err2", 32'(er2), 32'(e2_er));
`endif
    endtask

    // Apply one cycle of stimulus, advance the expected state, then compare
    task automatic step(input logic r, input logic iv,
                        input logic [2:0] xa1, input logic [2:0] xb1,
                        input logic [5:0] xa2, input logic [5:0] xb2);
        logic [23:0] s;
        logic        co, er;
        @(negedge clk);
        rst = r; in_valid = iv; a1 = xa1; b1 = xb1; a2 = xa2; b2 = xb2;
        @(posedge clk);
        #1;
        if (r) begin
            e1_v = 0; e1_s = '0; e1_co = 0; e1_er = 0;
            e2_v = 0; e2_s = '0; e2_co = 0; e2_er = 0;
        end else if (iv) begin
            model(1, {21'b0, xa1}, {21'b0, xb1}, s, co, er);
            e1_v = 1; e1_s = s[2:0]; e1_co = co; e1_er = er;
            model(2, {18'b0, xa2}, {18'b0, xb2}, s, co, er);
            e2_v = 1; e2_s = s[5:0]; e2_co = co; e2_er = er;
        end else begin
            e1_v = 0;
            e2_v = 0;
        end
        check_all();
    endtask

    function automatic logic [5:0] rnd_legal2();
        return {3'($urandom_range(0, 4)), 3'($urandom_range(0, 4))};
    endfunction

    logic [2:0] da_q [6];
    logic [2:0] db_q [6];

    initial begin
        da_q = '{3'd3, 3'd2, 3'd1, 3'd0, 3'd1, 3'd4};
        db_q = '{3'd4, 3'd4, 3'd4, 3'd2, 3'd2, 3'd4};
        e1_v = 0; e1_s = '0; e1_co = 0; e1_er = 0;
        e2_v = 0; e2_s = '0; e2_co = 0; e2_er = 0;

        // Reset state
        step(1'b1, 1'b0, 3'd0, 3'd0, 6'd0, 6'd0);
        step(1'b1, 1'b0, 3'd0, 3'd0, 6'd0, 6'd0);

        // Directed single-digit pairs with known answers
        for (int i = 0; i < 6; i++)
            step(1'b0, 1'b1, da_q[i], db_q[i], rnd_legal2(), rnd_legal2());
        // Spot-check the literal expectations as well
        step(1'b0, 1'b1, 3'd3, 3'd4, 6'd0, 6'd0);
        chk("lit_3p4_sum", 32'(s1), 32'd2);
        chk("lit_3p4_co",  32'(co1), 32'd1);

        // Exhaustive legal sweep, back-to-back
        for (int a = 0; a < 5; a++)
            for (int b = 0; b < 5; b++)
                step(1'b0, 1'b1, 3'(a), 3'(b), rnd_legal2(), rnd_legal2());

        // Two-digit full ripple: 44 + 01 = (1)00
        step(1'b0, 1'b1, 3'd1, 3'd1, {3'd4, 3'd4}, {3'd0, 3'd1});
        chk("ripple_sum", 32'(s2), 32'd0);
        chk("ripple_co",  32'(co2), 32'd1);

        // Non-zero result then an idle cycle must hold it
        step(1'b0, 1'b1, 3'd2, 3'd1, {3'd1, 3'd2}, {3'd1, 3'd1});
        step(1'b0, 1'b0, 3'd4, 3'd4, 6'd0, 6'd0);

        // Reset beats a same-edge capture, then idle holds zero
        step(1'b1, 1'b1, 3'd4, 3'd4, {3'd4, 3'd4}, {3'd4, 3'd4});
        step(1'b0, 1'b0, 3'd4, 3'd4, 6'd0, 6'd0);

`ifdef PENTA_ERR_EN
        // Out-of-range digit flagged, then a clean pair clears it
        step(1'b0, 1'b1, 3'd5, 3'd1, {3'd0, 3'd5}, {3'd0, 3'd1});
        chk("err_flag", 32'(er1), 32'd1);
        step(1'b0, 1'b1, 3'd1, 3'd1, {3'd0, 3'd1}, {3'd0, 3'd1});
        chk("err_clr_sum", 32'(s1), 32'd2);
`endif

        // Randomized traffic including idle cycles, resets and illegal digits
        for (int n = 0; n < 300; n++) begin
            logic r, iv, ill;
            r   = ($urandom_range(0, 24) == 0);
            iv  = ($urandom_range(0, 3) != 0);
            ill = ($urandom_range(0, 3) == 0);
            if (ill)
                step(r, iv, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                     6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)));
            else
                step(r, iv, 3'($urandom_range(0, 4)), 3'($urandom_range(0, 4)),
                     rnd_legal2(), rnd_legal2());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_hw17
`default_nettype wire
